// File: rtl/data_mem_ctrl.sv
// Round-robin arbiter and sequencer that lets NUM_CORES cores share one data RAM.
// Each access is latched at grant time, and the served core gets a one-cycle done pulse.
module data_mem_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 512
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_done,
  output logic                          core_err,
  output logic [DATA_W-1:0]             core_rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_wr,
  output logic                          mem_rd,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int IDX_W = $clog2(NUM_CORES);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, DONE} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     ptr, idx, grant_idx;
  logic                 grant_vld, grant_oor, err_q;
  logic [ADDR_W-1:0]    grant_addr;
  logic [NUM_CORES-1:0] mask, eligible, idx_onehot;

  // The core served last is hidden for exactly one IDLE cycle after its DONE.
  assign eligible   = core_req & ~mask;
  assign idx_onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << idx;
  assign grant_addr = core_addr[grant_idx*ADDR_W +: ADDR_W];
  assign grant_oor  = 64'(grant_addr) >= 64'(MEM_DEPTH);

  // Descending scan, so the candidate closest to ptr is assigned last and wins.
  always_comb begin
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % NUM_CORES;
      if (eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          if (grant_oor)               state_nxt = DONE;
          else if (core_we[grant_idx]) state_nxt = WRITE;
          else                         state_nxt = READ;
        end
      end
      WRITE:   state_nxt = DONE;
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    core_done = '0;
    core_err  = 1'b0;
    case (state)
      WRITE:         mem_wr = 1'b1;
      READ, CAPTURE: mem_rd = 1'b1;
      DONE: begin
        core_done = idx_onehot;
        core_err  = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= '0;
      idx        <= '0;
      err_q      <= 1'b0;
      mask       <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rdata <= '0;
    end else begin
      mask <= (state == DONE) ? idx_onehot : '0;
      if (state == IDLE && grant_vld) begin
        idx       <= grant_idx;
        err_q     <= grant_oor;
        mem_addr  <= grant_addr;
        mem_wdata <= core_wdata[grant_idx*DATA_W +: DATA_W];
        ptr       <= (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
      if (state == CAPTURE) core_rdata <= mem_rdata;
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter NUM_CORES, default 4, number of requesting cores (2..8).
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 Parameter DATA_W, default 64, memory word width.
REQ-004 Parameter MEM_DEPTH, default 512, number of implemented data-memory words.
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port rst_n  input  1  reset, synchronous, active-low.
REQ-007 Port core_req  input  NUM_CORES  per-core access request, held high until core_done.
REQ-008 Port core_we  input  NUM_CORES  per-core access type: 1 = write, 0 = read.
REQ-009 Port core_addr  input  NUM_CORES*ADDR_W  packed per-core addresses, core i at bits [i*ADDR_W +: ADDR_W].
REQ-010 Port core_wdata  input  NUM_CORES*DATA_W  packed per-core write data, same packing.
REQ-011 Port core_done  output  NUM_CORES  one-hot, one-cycle completion pulse to the served core.
REQ-012 Port core_err  output  1  valid with core_done; 1 = address out of range, no memory access made.
REQ-013 Port core_rdata  output  DATA_W  read data, valid in the core_done cycle of a read; held until next read completes.
REQ-014 Port mem_addr  output  ADDR_W  to data RAM ADDBUS.
REQ-015 Port mem_wdata  output  DATA_W  to data RAM DATAIN.
REQ-016 Port mem_wr  output  1  to data RAM WR; RAM writes on clk rising edge while high.
REQ-017 Port mem_rd  output  1  to data RAM RD; RAM updates DATAOUT on RD rising edge.
REQ-018 Port mem_rdata  input  DATA_W  from data RAM DATAOUT.

Function
REQ-019 The block SHALL implement FSM states IDLE, WRITE, READ, CAPTURE, DONE.
REQ-020 IDLE: if any eligible core_req is high, the block SHALL grant one core round-robin, latch its we/addr/wdata and index, and move to WRITE (we=1) or READ (we=0); otherwise stay in IDLE.
REQ-021 Round-robin: search starts at pointer ptr (reset 0), ascending with wrap; after a grant to core i, ptr SHALL become (i+1) mod NUM_CORES.
REQ-022 Latched address >= MEM_DEPTH: the block SHALL go directly IDLE -> DONE with core_err=1, mem_wr and mem_rd never asserted, core_rdata unchanged.
REQ-023 WRITE (1 cycle): mem_wr=1, mem_addr/mem_wdata = latched values; next state DONE.
REQ-024 READ (1 cycle): mem_rd=1, mem_addr = latched address; next state CAPTURE.
REQ-025 CAPTURE (1 cycle): mem_rd stays 1; core_rdata SHALL register mem_rdata at end of cycle; next state DONE.
REQ-026 DONE (1 cycle): core_done[idx]=1, core_err per REQ-012, mem_wr=mem_rd=0; next state IDLE.
REQ-027 mem_rd SHALL be low for at least one cycle between consecutive reads (guaranteed by DONE and IDLE), so every read produces a fresh RD rising edge.
REQ-028 mem_wr and mem_rd SHALL never be high in the same cycle; both SHALL be low in IDLE and DONE.
REQ-029 Latency from grant cycle (IDLE): write done at +2 cycles, read done at +3 cycles, out-of-range done at +1 cycle.
REQ-030 In the IDLE cycle immediately after DONE, the just-served core's core_req SHALL be ignored; it becomes eligible again the cycle after.
REQ-031 Requests asserted while the FSM is busy SHALL wait; core_* inputs of non-granted cores are not sampled until their grant.
REQ-032 Changes to a granted core's inputs after the grant cycle SHALL NOT affect the transaction in progress.
REQ-033 mem_addr and mem_wdata SHALL hold the last latched values outside WRITE/READ/CAPTURE.

Reset
REQ-034 With rst_n low at a rising clk edge: state = IDLE, ptr = 0, core_done = 0, core_err = 0, core_rdata = 0, mem_wr = 0, mem_rd = 0, mem_addr = 0, mem_wdata = 0.
REQ-035 Reset asserted mid-transaction SHALL abort it: no core_done pulse, mem_wr/mem_rd low from the next cycle.

Verification
REQ-036 Write then read: core 0 writes addr 5, data 64'hDEAD_BEEF_0000_0001; after done, core 0 reads addr 5 -> core_rdata = 64'hDEAD_BEEF_0000_0001, done 3 cycles after grant.
REQ-037 Preloaded read: core 2 reads addr 1 -> core_rdata = 64'h0001_0002_0003_0004, core_err = 0.
REQ-038 Contention: cores 0-3 request simultaneously after reset -> grant order 0,1,2,3; core 0 re-requests immediately -> served after core 3.
REQ-039 Out of range: core 1 reads addr 600 -> core_done[1] one cycle after grant, core_err = 1, mem_rd never high, core_rdata unchanged.
REQ-040 Back-to-back reads by one core: mem_rd shows a low cycle between the two read pulses; both return correct data.
REQ-041 Reset during CAPTURE: rst_n low one cycle -> no core_done, all outputs at REQ-034 values, next request granted to core 0.
